tx_fifo_ctrl: RTL and testbench

//  Controls the transmit-layer FIFO bank: moves words from two virtual-channel FIFOs (VC0, VC1) into two

---
 rtl/tx_fifo_ctrl.sv | 168 ++++++++++++++++
 tb/tb_tx_fifo_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_ctrl.sv
// Transmit-layer FIFO bank controller: init/threshold sequencing plus a strict-priority
// VC0-over-VC1 arbiter that routes each popped word to D0 or D1 through a two-stage pipeline.
module tx_fifo_ctrl #(
  parameter int DATA_WIDTH   = 6,
  parameter int DEST_BIT     = 4,
  parameter int UMBRAL_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    init,
  input  logic [UMBRAL_WIDTH-1:0] umbral_vc_in,
  input  logic [UMBRAL_WIDTH-1:0] umbral_d_in,
  input  logic                    empty_vc0,
  input  logic                    empty_vc1,
  input  logic [DATA_WIDTH-1:0]   data_vc0,
  input  logic [DATA_WIDTH-1:0]   data_vc1,
  input  logic                    almost_full_d0,
  input  logic                    almost_full_d1,
  input  logic                    full_d0,
  input  logic                    full_d1,
  input  logic                    error_vc0,
  input  logic                    error_vc1,
  input  logic                    error_d0,
  input  logic                    error_d1,
  output logic                    fifo_init_out,
  output logic [UMBRAL_WIDTH-1:0] umbral_vc_out,
  output logic [UMBRAL_WIDTH-1:0] umbral_d_out,
  output logic                    pop_vc0,
  output logic                    pop_vc1,
  output logic                    push_d0,
  output logic                    push_d1,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    idle_out,
  output logic                    active_out,
  output logic                    error_out
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [UMBRAL_WIDTH-1:0] umbral_vc_r;
  logic [UMBRAL_WIDTH-1:0] umbral_d_r;
  logic                    pend_valid_r;
  logic                    pend_src_r;
  logic                    push_d0_r;
  logic                    push_d1_r;
  logic [DATA_WIDTH-1:0]   data_out_r;
  logic [DATA_WIDTH-1:0]   pend_word_s;
  logic                    any_err_s;
  logic                    dest_ok_s;
  logic                    keep_s;

  assign any_err_s = error_vc0 | error_vc1 | error_d0 | error_d1;
  assign dest_ok_s = ~almost_full_d0 & ~almost_full_d1 & ~full_d0 & ~full_d1;
  // The pipeline only advances while the FSM stays in ACTIVE; leaving to ERROR/INIT drops in-flight words.
  assign keep_s    = (state_nxt_s == ST_ACTIVE);

  assign pop_vc0 = (state_r == ST_ACTIVE) & dest_ok_s & ~empty_vc0;
  assign pop_vc1 = (state_r == ST_ACTIVE) & dest_ok_s & empty_vc0 & ~empty_vc1;

  assign umbral_vc_out = umbral_vc_r;
  assign umbral_d_out  = umbral_d_r;
  assign push_d0       = push_d0_r;
  assign push_d1       = push_d1_r;
  assign data_out      = data_out_r;

  // Next-state selection: init low dominates, then error, then the normal flow.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RESET:  state_nxt_s = ST_INIT;
      ST_INIT: begin
        if (init) state_nxt_s = ST_IDLE;
        else      state_nxt_s = ST_INIT;
      end
      ST_IDLE: begin
        if (!init)                       state_nxt_s = ST_INIT;
        else if (any_err_s)              state_nxt_s = ST_ERROR;
        else if (!empty_vc0 || !empty_vc1) state_nxt_s = ST_ACTIVE;
        else                             state_nxt_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (!init)                                       state_nxt_s = ST_INIT;
        else if (any_err_s)                              state_nxt_s = ST_ERROR;
        else if (empty_vc0 && empty_vc1 && !pend_valid_r) state_nxt_s = ST_IDLE;
        else                                             state_nxt_s = ST_ACTIVE;
      end
      ST_ERROR: begin
        if (!init) state_nxt_s = ST_INIT;
        else       state_nxt_s = ST_ERROR;
      end
      default:   state_nxt_s = ST_INIT;
    endcase
  end

  // Moore decodes of the current state.
  always_comb begin
    fifo_init_out = 1'b0;
    idle_out      = 1'b0;
    active_out    = 1'b0;
    error_out     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        fifo_init_out = 1'b1;
        idle_out      = 1'b1;
      end
      ST_ACTIVE: begin
        fifo_init_out = 1'b1;
        active_out    = 1'b1;
      end
      ST_ERROR: begin
        fifo_init_out = 1'b1;
        error_out     = 1'b1;
      end
      default: fifo_init_out = 1'b0;
    endcase
  end

  // Read data of the VC that was popped last cycle.
  always_comb begin
    if (pend_src_r) pend_word_s = data_vc1;
    else            pend_word_s = data_vc0;
  end

  // State register and threshold latches.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_r     <= ST_RESET;
      umbral_vc_r <= {UMBRAL_WIDTH{1'b0}};
      umbral_d_r  <= {UMBRAL_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_INIT) begin
        umbral_vc_r <= umbral_vc_in;
        umbral_d_r  <= umbral_d_in;
      end else begin
        umbral_vc_r <= umbral_vc_r;
        umbral_d_r  <= umbral_d_r;
      end
    end
  end

  // Pop-to-push pipeline: pending stage, then registered push/data towards the D FIFOs.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pend_valid_r <= 1'b0;
      pend_src_r   <= 1'b0;
      push_d0_r    <= 1'b0;
      push_d1_r    <= 1'b0;
      data_out_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      pend_valid_r <= (pop_vc0 | pop_vc1) & keep_s;
      pend_src_r   <= pop_vc1;
      push_d0_r    <= pend_valid_r & keep_s & ~pend_word_s[DEST_BIT];
      push_d1_r    <= pend_valid_r & keep_s & pend_word_s[DEST_BIT];
      if (pend_valid_r && keep_s) data_out_r <= pend_word_s;
      else                        data_out_r <= data_out_r;
    end
  end

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// Bench for tx_fifo_ctrl: VC FIFOs modelled as queues, expected outputs from a mode/in-flight
// scoreboard; directed scenarios followed by randomized traffic, flags, errors and resets.
module tb_tx_fifo_ctrl;
  localparam int DW = 6;
  localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          init;
  logic [3:0]    umbral_vc_in, umbral_d_in;
  logic          empty_vc0, empty_vc1;
  logic [DW-1:0] data_vc0, data_vc1;
  logic          almost_full_d0, almost_full_d1, full_d0, full_d1;
  logic          error_vc0, error_vc1, error_d0, error_d1;
  logic          fifo_init_out;
  logic [3:0]    umbral_vc_out, umbral_d_out;
  logic          pop_vc0, pop_vc1, push_d0, push_d1;
  logic [DW-1:0] data_out;
  logic          idle_out, active_out, error_out;

  always #5 clk = ~clk;

  tx_fifo_ctrl dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .umbral_vc_in(umbral_vc_in), .umbral_d_in(umbral_d_in),
    .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
    .data_vc0(data_vc0), .data_vc1(data_vc1),
    .almost_full_d0(almost_full_d0), .almost_full_d1(almost_full_d1),
    .full_d0(full_d0), .full_d1(full_d1),
    .error_vc0(error_vc0), .error_vc1(error_vc1), .error_d0(error_d0), .error_d1(error_d1),
    .fifo_init_out(fifo_init_out), .umbral_vc_out(umbral_vc_out), .umbral_d_out(umbral_d_out),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_d0(push_d0), .push_d1(push_d1),
    .data_out(data_out), .idle_out(idle_out), .active_out(active_out), .error_out(error_out)
  );

  typedef struct {
    logic [DW-1:0] w;
    int            due;
  } fl_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            m_mode;
  logic [3:0]    m_uvc, m_ud;
  logic [DW-1:0] m_data;
  fl_t           fl_q[$];
  logic [DW-1:0] vc0_q[$];
  logic [DW-1:0] vc1_q[$];

  function automatic logic [21:0] obs_vec();
    return {fifo_init_out, umbral_vc_out, umbral_d_out, pop_vc0, pop_vc1, push_d0, push_d1,
            data_out, idle_out, active_out, error_out};
  endfunction

  task automatic check_eq(string tag, logic [21:0] obs, logic [21:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic update_empty();
    empty_vc0 = (vc0_q.size() == 0);
    empty_vc1 = (vc1_q.size() == 0);
  endtask

  // One clock cycle: compare outputs against the scoreboard, then advance model and VC FIFOs.
  task automatic tick();
    logic ok, any_err, inflight, e_pop0, e_pop1, e_push0, e_push1, e_fi, a_pop0, a_pop1;
    logic [DW-1:0] e_data;
    int nm;
    fl_t keep_q[$];
    update_empty();
    #1;
    ok = !(almost_full_d0 || almost_full_d1 || full_d0 || full_d1);
    e_pop0 = (m_mode == M_ACTIVE) && ok && (vc0_q.size() > 0);
    e_pop1 = (m_mode == M_ACTIVE) && ok && (vc0_q.size() == 0) && (vc1_q.size() > 0);
    e_push0 = 1'b0;
    e_push1 = 1'b0;
    e_data = m_data;
    foreach (fl_q[i]) begin
      if (fl_q[i].due == cyc) begin
        e_data = fl_q[i].w;
        if (fl_q[i].w[4]) e_push1 = 1'b1;
        else              e_push0 = 1'b1;
      end
    end
    m_data = e_data;
    e_fi = (m_mode == M_IDLE) || (m_mode == M_ACTIVE) || (m_mode == M_ERROR);
    check_eq("outputs", obs_vec(),
             {e_fi, m_uvc, m_ud, e_pop0, e_pop1, e_push0, e_push1, e_data,
              m_mode == M_IDLE, m_mode == M_ACTIVE, m_mode == M_ERROR});
    any_err = error_vc0 || error_vc1 || error_d0 || error_d1;
    inflight = 1'b0;
    foreach (fl_q[i]) if (fl_q[i].due > cyc) inflight = 1'b1;
    if (m_mode == M_RESET)      nm = M_INIT;
    else if (!init)             nm = M_INIT;
    else if (m_mode == M_INIT)  nm = M_IDLE;
    else if (m_mode == M_ERROR) nm = M_ERROR;
    else if (any_err)           nm = M_ERROR;
    else if (m_mode == M_IDLE)  nm = (vc0_q.size() + vc1_q.size() > 0) ? M_ACTIVE : M_IDLE;
    else                        nm = (vc0_q.size() + vc1_q.size() == 0 && !inflight) ? M_IDLE : M_ACTIVE;
    if (m_mode == M_INIT) begin
      m_uvc = umbral_vc_in;
      m_ud  = umbral_d_in;
    end
    if (e_pop0) fl_q.push_back('{w: vc0_q[0], due: cyc + 2});
    if (e_pop1) fl_q.push_back('{w: vc1_q[0], due: cyc + 2});
    foreach (fl_q[i]) if (fl_q[i].due > cyc) keep_q.push_back(fl_q[i]);
    fl_q = keep_q;
    if (nm == M_ERROR || nm == M_INIT) fl_q.delete();
    a_pop0 = pop_vc0;
    a_pop1 = pop_vc1;
    @(posedge clk);
    #1;
    if (a_pop0 && vc0_q.size() > 0) data_vc0 = vc0_q.pop_front();
    if (a_pop1 && vc1_q.size() > 0) data_vc1 = vc1_q.pop_front();
    m_mode = nm;
    cyc++;
    update_empty();
  endtask

  task automatic async_reset();
    reset_L = 1'b0;
    #1;
    check_eq("async_reset", obs_vec(), 22'd0);
    m_mode = M_RESET;
    m_uvc = 4'd0;
    m_ud = 4'd0;
    m_data = '0;
    fl_q.delete();
    #1;
    reset_L = 1'b1;
  endtask

  task automatic tickn(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset_L = 1'b0;
    init = 1'b0;
    umbral_vc_in = 4'd3;
    umbral_d_in = 4'd2;
    data_vc0 = '0;
    data_vc1 = '0;
    {almost_full_d0, almost_full_d1, full_d0, full_d1} = 4'b0000;
    {error_vc0, error_vc1, error_d0, error_d1} = 4'b0000;
    m_mode = M_RESET;
    m_uvc = 4'd0;
    m_ud = 4'd0;
    m_data = '0;
    update_empty();
    #2;
    check_eq("reset_before_edge", obs_vec(), 22'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("reset_held", obs_vec(), 22'd0);
    reset_L = 1'b1;

    // bring-up: RESET -> INIT (held) -> IDLE, thresholds latched then frozen
    tickn(2);
    init = 1'b1;
    tickn(2);
    umbral_vc_in = 4'd9;
    umbral_d_in = 4'd7;
    tickn(2);

    // three words to D0, D1, D0
    vc0_q.push_back(6'b000001);
    vc0_q.push_back(6'b010010);
    vc0_q.push_back(6'b000011);
    tickn(8);

    // VC0 priority over VC1
    for (int i = 0; i < 3; i++) begin
      vc0_q.push_back(6'($urandom_range(0, 63)));
      vc1_q.push_back(6'($urandom_range(0, 63)));
    end
    tickn(11);

    // almost-full backpressure mid-stream
    for (int i = 0; i < 6; i++) vc0_q.push_back(6'($urandom_range(0, 63)));
    tickn(2);
    almost_full_d1 = 1'b1;
    tickn(3);
    almost_full_d1 = 1'b0;
    tickn(8);

    // error in ACTIVE, sticky ERROR, recovery through INIT
    for (int i = 0; i < 4; i++) vc0_q.push_back(6'($urandom_range(0, 63)));
    tickn(3);
    error_d0 = 1'b1;
    tick();
    error_d0 = 1'b0;
    tickn(3);
    init = 1'b0;
    tickn(2);
    init = 1'b1;
    tickn(8);

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) vc0_q.push_back(6'($urandom_range(0, 63)));
    tickn(3);
    async_reset();
    tickn(12);

    // randomized traffic, flags, errors, init drops and resets
    for (int n = 0; n < 800; n++) begin
      if (vc0_q.size() < 12 && $urandom_range(0, 2) == 0) vc0_q.push_back(6'($urandom));
      if (vc1_q.size() < 12 && $urandom_range(0, 3) == 0) vc1_q.push_back(6'($urandom));
      almost_full_d0 = ($urandom_range(0, 9) == 0);
      almost_full_d1 = ($urandom_range(0, 9) == 0);
      full_d0 = ($urandom_range(0, 19) == 0);
      full_d1 = ($urandom_range(0, 19) == 0);
      error_vc0 = ($urandom_range(0, 299) == 0);
      error_vc1 = ($urandom_range(0, 299) == 0);
      error_d0 = ($urandom_range(0, 299) == 0);
      error_d1 = ($urandom_range(0, 299) == 0);
      init = ($urandom_range(0, 59) != 0);
      umbral_vc_in = 4'($urandom);
      umbral_d_in = 4'($urandom_range(2, 15));
      tick();
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    // drain
    {almost_full_d0, almost_full_d1, full_d0, full_d1} = 4'b0000;
    {error_vc0, error_vc1, error_d0, error_d1} = 4'b0000;
    init = 1'b1;
    tickn(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
